// File: rtl/layer7_weight_loader.sv
// layer7_weight_loader: turns 32-bit bus words (two 16-bit weights each) into a
// gapless stream of single-weight writes for the layer-7 weight memory, and flags
// completion once TOTAL_WEIGHTS weights have been written.
// Optional feature: define LAYER7_WEIGHT_LOADER_CHECKSUM_EN to add weight_checksum,
// the modulo-2^16 sum of every weight written in the current load.
module layer7_weight_loader #(
    parameter int TOTAL_WEIGHTS = 400,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              write_weight_signal,
    output logic [15:0]       write_weight_data,
    output logic [ADDR_W-1:0] write_weight_addr,
    output logic              weight_store_done,
    output logic              busy
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       weight_checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] COUNT_FULL = ADDR_W'(TOTAL_WEIGHTS);
    localparam logic [ADDR_W-1:0] COUNT_LAST = ADDR_W'(TOTAL_WEIGHTS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic [31:0]       hold;
    logic              hold_full;
    logic              emit;
    logic              emit_hi;
    logic              restart;
    logic              accept;
    logic              count_full;
    logic              count_last;
    logic [15:0]       emit_word;

    assign count_full = (count == COUNT_FULL);
    assign count_last = (count == COUNT_LAST);
    assign accept     = in_ready & in_valid;
    assign emit_word  = emit_hi ? hold[31:16] : hold[15:0];
    assign busy       = (state == LOAD_LO) || (state == LOAD_HI);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input handshake and write-issue decisions
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        emit       = 1'b0;
        emit_hi    = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD_LO;
                    restart    = 1'b1;
                end
            end
            LOAD_LO: begin
                // The holding register is either waiting for a word or has its
                // low half due; a full count means the last write already issued.
                if (count_full) begin
                    state_next = DONE;
                end else if (hold_full) begin
                    emit       = 1'b1;
                    state_next = LOAD_HI;
                end else begin
                    in_ready = 1'b1;
                end
            end
            LOAD_HI: begin
                // A full count here means the final weight was a low half: the
                // unused high half is dropped without a write.
                if (count_full) begin
                    state_next = DONE;
                end else begin
                    emit       = 1'b1;
                    emit_hi    = 1'b1;
                    in_ready   = !count_last;
                    state_next = LOAD_LO;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding register, weight counter, registered write port and done flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            count               <= '0;
            hold                <= '0;
            hold_full           <= 1'b0;
            write_weight_signal <= 1'b0;
            write_weight_data   <= '0;
            write_weight_addr   <= '0;
            weight_store_done   <= 1'b0;
        end else begin
            write_weight_signal <= emit;
            if (emit) begin
                write_weight_data <= emit_word;
                write_weight_addr <= count;
                count             <= count + 1'b1;
            end
            if (restart) begin
                count             <= '0;
                hold              <= '0;
                hold_full         <= 1'b0;
                weight_store_done <= 1'b0;
            end else begin
                if (accept) begin
                    hold      <= in_data;
                    hold_full <= 1'b1;
                end else if (emit_hi) begin
                    hold_full <= 1'b0;
                end
                if (busy && state_next == DONE) begin
                    weight_store_done <= 1'b1;
                end
            end
        end
    end

`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    // Running sum of every weight written in the current load
    always_ff @(posedge clk) begin
        if (!rst) begin
            weight_checksum <= '0;
        end else if (restart) begin
            weight_checksum <= '0;
        end else if (emit) begin
            weight_checksum <= weight_checksum + emit_word;
        end
    end
`endif

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Bench for layer7_weight_loader: one instance with 400 weights and one with an
// odd count of 5. A posedge model turns accepted words into expected writes in a
// per-instance queue; a negedge monitor pops and compares every issued write.
module tb_layer7_weight_loader;

    localparam int unsigned TW0 = 400;
    localparam int unsigned TW1 = 5;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start    [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_data  [2];
    logic        wsig     [2];
    logic [15:0] wdata    [2];
    logic [15:0] waddr    [2];
    logic        done     [2];
    logic        busy     [2];
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] csum     [2];
    logic [15:0] exp_sum  [2];
`endif

    wr_t         q [2][$];
    bit          rst_edge   [2];
    bit          start_edge [2];
    bit          act        [2];
    int unsigned idx        [2];
    bit          done_exp   [2];
    bit          busy_exp   [2];
    bit          burst      [2];
    int unsigned first_cyc  [2];
    int unsigned cyc = 0;
    int unsigned vec = 0;
    int unsigned err = 0;

    always #5 clk = ~clk;

    layer7_weight_loader #(.TOTAL_WEIGHTS(TW0), .ADDR_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]),
        .write_weight_signal(wsig[0]), .write_weight_data(wdata[0]),
        .write_weight_addr(waddr[0]), .weight_store_done(done[0]), .busy(busy[0])
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        , .weight_checksum(csum[0])
`endif
    );

    layer7_weight_loader #(.TOTAL_WEIGHTS(TW1), .ADDR_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]),
        .write_weight_signal(wsig[1]), .write_weight_data(wdata[1]),
        .write_weight_addr(waddr[1]), .weight_store_done(done[1]), .busy(busy[1])
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        , .weight_checksum(csum[1])
`endif
    );

    function automatic int unsigned total(input int l);
        return (l == 0) ? TW0 : TW1;
    endfunction

    // Reference model: a load is a list of weights numbered 0..total-1; every
    // accepted word contributes its low then high weight until the list is full.
    initial begin : model
        int unsigned n;
        int unsigned tot;
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        logic [15:0] s;
`endif
        wr_t w;
        forever begin
            @(posedge clk);
            for (int l = 0; l < 2; l++) begin
                tot = total(l);
                n = idx[l];
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                s = exp_sum[l];
`endif
                start_edge[l] = 1'b0;
                rst_edge[l]   = !rst;
                if (!rst) begin
                    n = 0;
                    act[l] = 1'b0;
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                    s = '0;
`endif
                end else if (start[l] && (!act[l] || n >= tot)) begin
                    n = 0;
                    act[l] = 1'b1;
                    start_edge[l] = 1'b1;
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                    s = '0;
`endif
                end else if (in_valid[l] && in_ready[l] && act[l]) begin
                    for (int h = 0; h < 2; h++) begin
                        if (n < tot) begin
                            w.addr = 16'(n);
                            w.data = (h == 0) ? in_data[l][15:0] : in_data[l][31:16];
                            q[l].push_back(w);
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                            s = s + w.data;
`endif
                            n++;
                        end
                    end
                end
                idx[l] = n;
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                exp_sum[l] = s;
`endif
            end
        end
    end

    // Monitor: compares everything the DUTs present, half a cycle after each edge
    initial begin : monitor
        wr_t e;
        int unsigned tot;
        forever begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < 2; l++) begin
                tot = total(l);
                if (rst_edge[l]) begin
                    vec++;
                    if (wsig[l] || in_ready[l] || busy[l] || done[l] ||
                        wdata[l] != 16'h0 || waddr[l] != 16'h0) begin
                        err++;
                        $display("FAIL reset_state lane%0d: sig=%b ready=%b busy=%b done=%b data=%h addr=%0d, required all zero",
                                 l, wsig[l], in_ready[l], busy[l], done[l], wdata[l], waddr[l]);
                    end
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                    vec++;
                    if (csum[l] != 16'h0) begin
                        err++;
                        $display("FAIL reset_checksum lane%0d: got %h, required 0000", l, csum[l]);
                    end
`endif
                    q[l].delete();
                    done_exp[l] = 1'b0;
                    busy_exp[l] = 1'b0;
                end else begin
                    if (start_edge[l]) begin
                        done_exp[l] = 1'b0;
                        busy_exp[l] = 1'b1;
                    end
                    vec++;
                    if (done[l] !== done_exp[l] || busy[l] !== busy_exp[l]) begin
                        err++;
                        $display("FAIL status lane%0d cyc%0d: done=%b busy=%b, required done=%b busy=%b",
                                 l, cyc, done[l], busy[l], done_exp[l], busy_exp[l]);
                    end
                    vec++;
                    if (in_ready[l] && (!busy_exp[l] || idx[l] >= tot)) begin
                        err++;
                        $display("FAIL ready lane%0d cyc%0d: in_ready=1, required 0 (busy_exp=%b weights_taken=%0d)",
                                 l, cyc, busy_exp[l], idx[l]);
                    end
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
                    if (done_exp[l]) begin
                        vec++;
                        if (csum[l] != exp_sum[l]) begin
                            err++;
                            $display("FAIL checksum lane%0d: got %h, required %h", l, csum[l], exp_sum[l]);
                        end
                    end
`endif
                    if (wsig[l]) begin
                        vec++;
                        if (q[l].size() == 0) begin
                            err++;
                            $display("FAIL unexpected_write lane%0d cyc%0d: addr=%0d data=%h, required no write",
                                     l, cyc, waddr[l], wdata[l]);
                        end else begin
                            e = q[l].pop_front();
                            if (waddr[l] != e.addr || wdata[l] != e.data) begin
                                err++;
                                $display("FAIL write lane%0d cyc%0d: addr=%0d data=%h, required addr=%0d data=%h",
                                         l, cyc, waddr[l], wdata[l], e.addr, e.data);
                            end
                            if (e.addr == 16'h0) first_cyc[l] = cyc;
                            if (32'(e.addr) == tot - 1) begin
                                done_exp[l] = 1'b1;
                                busy_exp[l] = 1'b0;
                                if (burst[l]) begin
                                    vec++;
                                    if (cyc - first_cyc[l] != tot - 1) begin
                                        err++;
                                        $display("FAIL burst_span lane%0d: %0d cycles first-to-last write, required %0d",
                                                 l, cyc - first_cyc[l], tot - 1);
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int l);
        start[l] = 1'b1;
        tick();
        start[l] = 1'b0;
    endtask

    // pattern: 0 ramp k, 1 random, 2 all 0x0101, 3 ramp k+1
    // mode: 0 valid held, 1 valid toggling, 2 random valid
    task automatic feed(input int l, input int mode, input int pattern,
                        input int unsigned mid_at, input int unsigned abort_at);
        int unsigned words;
        int unsigned sent;
        int unsigned guard;
        logic [31:0] w;
        logic        v;
        logic        acc;
        words = (total(l) + 1) / 2;
        sent  = 0;
        guard = 0;
        w     = '0;
        while (sent < words && guard < 20000) begin
            case (pattern)
                0:       w = {16'(2 * sent + 1), 16'(2 * sent)};
                1:       if (guard == 0 || acc) w = $urandom;
                2:       w = 32'h0101_0101;
                default: w = {16'(2 * sent + 2), 16'(2 * sent + 1)};
            endcase
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid[l] = v;
            in_data[l]  = v ? w : $urandom;
            start[l]    = (mid_at != 0 && sent == mid_at && guard % 2 == 0);
            acc = v && in_ready[l];
            tick();
            guard++;
            if (acc) begin
                sent++;
                if (abort_at != 0 && sent == abort_at) break;
            end
        end
        in_valid[l] = 1'b0;
        start[l]    = 1'b0;
        if (guard >= 20000) begin
            $display("FAIL feed_timeout lane%0d: %0d of %0d words accepted", l, sent, words);
            $fatal(1, "feed did not complete");
        end
    endtask

    task automatic wait_done(input int l);
        int unsigned guard;
        guard = 0;
        while (!done[l] && guard < 3000) begin
            tick();
            guard++;
        end
        if (!done[l]) begin
            $display("FAIL done_timeout lane%0d: done=0 after %0d cycles, required 1", l, guard);
            $fatal(1, "load did not complete");
        end
        repeat (4) tick();
    endtask

    initial begin : stimulus
        for (int l = 0; l < 2; l++) begin
            start[l]    = 1'b0;
            in_valid[l] = 1'b0;
            in_data[l]  = '0;
            burst[l]    = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();

        // back-to-back ramp: one write per cycle, addr and data 0..399
        burst[0] = 1'b1;
        pulse_start(0);
        feed(0, 0, 0, 0, 0);
        wait_done(0);
        burst[0] = 1'b0;

        // valid toggling every cycle, restarted from DONE
        pulse_start(0);
        feed(0, 1, 1, 0, 0);
        wait_done(0);

        // odd weight count: 1..5 written, 6 dropped
        pulse_start(1);
        feed(1, 0, 3, 0, 0);
        wait_done(1);

        // reset in the middle of a load, idle, then a fresh load
        pulse_start(0);
        feed(0, 2, 1, 0, 50);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        pulse_start(0);
        feed(0, 2, 1, 0, 0);
        wait_done(0);

        // start pulsed mid-load is ignored; start in DONE restarts
        pulse_start(0);
        feed(0, 2, 1, 25, 0);
        wait_done(0);
        pulse_start(0);
        feed(0, 2, 1, 0, 0);
        wait_done(0);

        // constant weights 0x0101 (checksum 0x9190 at done when enabled)
        pulse_start(0);
        feed(0, 0, 2, 0, 0);
        wait_done(0);

        // odd-count instance again with random data and bubbles
        pulse_start(1);
        feed(1, 2, 1, 0, 0);
        wait_done(1);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
